// File: rtl/pigasus_match_collector.sv
// Collects per-packet rule-ID matches into an ordered FWFT FIFO and emits one summary per packet.
// Optional statistics counters are built only when PIGASUS_MATCH_COLLECTOR_STATS_EN is defined.
module pigasus_match_collector #(
    parameter int DEPTH       = 16,
    parameter int MAX_MATCHES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] match_rules_ID,
    input  logic        match_last,
    input  logic        match_valid,
    output logic        match_release,
    output logic [31:0] m_id,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  sum_count,
    output logic        sum_overflow,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [31:0] stat_pkt,
    output logic [31:0] stat_match,
    output logic [31:0] stat_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
    localparam logic [7:0]  MAX_CNT  = 8'(MAX_MATCHES);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW:0]   ram_cnt;
    logic          head_valid_q, head_valid_d;
    logic [31:0]   head_id_q, head_id_d;

    logic [7:0]    pkt_cnt_q, pkt_cnt_d;
    logic          pkt_ovf_q, pkt_ovf_d;
    logic          sum_valid_q, sum_valid_d;
    logic [7:0]    sum_count_q, sum_count_d;
    logic          sum_overflow_q, sum_overflow_d;

    logic          fifo_full;
    logic          accept;
    logic          id_null;
    logic          store;
    logic          drop;
    logic          pop;
    logic          sum_pop;
    logic          head_free;
    logic          ram_we;
    logic [7:0]    cnt_final;
    logic          ovf_final;

    // A full FIFO refuses beats even when the head is popped this cycle.
    assign fifo_full     = (occ_q == FULL_OCC);
    assign match_release = rst_n && !fifo_full && (!match_last || !sum_valid_q || sum_ready);
    assign accept        = match_valid && match_release;
    assign id_null       = (match_rules_ID == 32'd0);
    assign store         = accept && !id_null && (pkt_cnt_q < MAX_CNT);
    assign drop          = accept && !id_null && !(pkt_cnt_q < MAX_CNT);
    assign pop           = head_valid_q && m_ready;
    assign sum_pop       = sum_valid_q && sum_ready;

    assign m_id         = head_id_q;
    assign m_valid      = rst_n && head_valid_q;
    assign sum_valid    = rst_n && sum_valid_q;
    assign sum_count    = sum_count_q;
    assign sum_overflow = sum_overflow_q;

    // The head register holds the oldest entry; the RAM holds the rest.
    // An empty head is refilled from RAM first, else straight from the input.
    always_comb begin
        head_valid_d = head_valid_q;
        head_id_d    = head_id_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        ram_we       = 1'b0;
        ram_cnt      = occ_q - {{AW{1'b0}}, head_valid_q};
        head_free    = !head_valid_q || pop;
        if (head_free) begin
            if (ram_cnt != '0) begin
                head_valid_d = 1'b1;
                head_id_d    = mem[rd_ptr_q];
                rd_ptr_d     = rd_ptr_q + 1'b1;
                ram_we       = store;
            end else if (store) begin
                head_valid_d = 1'b1;
                head_id_d    = match_rules_ID;
            end else begin
                head_valid_d = 1'b0;
            end
        end else begin
            ram_we = store;
        end
        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        occ_d = occ_q + {{AW{1'b0}}, store} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= match_rules_ID;
        end
    end

    always_comb begin
        cnt_final      = pkt_cnt_q + {7'd0, store};
        ovf_final      = pkt_ovf_q | drop;
        pkt_cnt_d      = cnt_final;
        pkt_ovf_d      = ovf_final;
        sum_valid_d    = sum_valid_q;
        sum_count_d    = sum_count_q;
        sum_overflow_d = sum_overflow_q;
        // A last beat is only accepted when the summary slot is free or draining.
        if (accept && match_last) begin
            sum_valid_d    = 1'b1;
            sum_count_d    = cnt_final;
            sum_overflow_d = ovf_final;
            pkt_cnt_d      = 8'd0;
            pkt_ovf_d      = 1'b0;
        end else if (sum_pop) begin
            sum_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            head_valid_q   <= 1'b0;
            head_id_q      <= '0;
            pkt_cnt_q      <= 8'd0;
            pkt_ovf_q      <= 1'b0;
            sum_valid_q    <= 1'b0;
            sum_count_q    <= 8'd0;
            sum_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            head_valid_q   <= head_valid_d;
            head_id_q      <= head_id_d;
            pkt_cnt_q      <= pkt_cnt_d;
            pkt_ovf_q      <= pkt_ovf_d;
            sum_valid_q    <= sum_valid_d;
            sum_count_q    <= sum_count_d;
            sum_overflow_q <= sum_overflow_d;
        end
    end

`ifdef PIGASUS_MATCH_COLLECTOR_STATS_EN
    logic [31:0] stat_pkt_q, stat_pkt_d;
    logic [31:0] stat_match_q, stat_match_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_pkt_d   = stat_pkt_q + {31'd0, accept && match_last};
        stat_match_d = stat_match_q + {31'd0, store};
        stat_drop_d  = stat_drop_q + {31'd0, drop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkt_q   <= '0;
            stat_match_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            stat_pkt_q   <= stat_pkt_d;
            stat_match_q <= stat_match_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign stat_pkt   = stat_pkt_q;
    assign stat_match = stat_match_q;
    assign stat_drop  = stat_drop_q;
`else
    assign stat_pkt   = 32'd0;
    assign stat_match = 32'd0;
    assign stat_drop  = 32'd0;
`endif

endmodule

// File: doc/pigasus_match_collector.md
PIGASUS_MATCH_COLLECTOR -- requirements
Module: pigasus_match_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning rule-ID FIFO entries (power of two, 4..256).
REQ-002 The block SHALL have parameter MAX_MATCHES, default 8, meaning maximum IDs stored per packet (1..255).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock.
REQ-004 The block SHALL have port rst_n  input  1  meaning synchronous active-low reset.
REQ-005 The block SHALL have port match_rules_ID  input  32  meaning rule ID from the SME wrapper.
REQ-006 The block SHALL have port match_last  input  1  meaning last ID beat of the packet.
REQ-007 The block SHALL have port match_valid  input  1  meaning the ID beat is valid.
REQ-008 The block SHALL have port match_release  output  1  meaning the beat is accepted (ready).
REQ-009 The block SHALL have port m_id  output  32  meaning the stored rule ID at the FIFO head.
REQ-010 The block SHALL have ports m_valid  output  1 and m_ready  input  1, meaning the pop handshake.
REQ-011 The block SHALL have port sum_count  output  8  meaning IDs stored for the completed packet.
REQ-012 The block SHALL have port sum_overflow  output  1  meaning IDs were dropped for that packet.
REQ-013 The block SHALL have ports sum_valid  output  1 and sum_ready  input  1, meaning the summary handshake.
REQ-014 The block SHALL have ports stat_pkt, stat_match, stat_drop, each output 32, meaning statistics counters.

Function
REQ-015 A beat SHALL be accepted when match_valid && match_release are both high.
REQ-016 match_release SHALL be !fifo_full && (!match_last || !sum_valid || sum_ready), where sum_valid is the registered summary flag.
REQ-017 An accepted ID of 0 SHALL be a null marker: never stored and never counted as a match or a drop.
REQ-018 For an accepted non-null ID with pkt_cnt < MAX_MATCHES, the ID SHALL be written to the FIFO and pkt_cnt SHALL be incremented.
REQ-019 For an accepted non-null ID with pkt_cnt == MAX_MATCHES, the ID SHALL be discarded and pkt_ovf SHALL be set.
REQ-020 On an accepted last beat, the block SHALL load, on the next edge, sum_count = the final pkt_cnt (including that beat), sum_overflow = the final pkt_ovf, and sum_valid = 1; it SHALL also clear pkt_cnt and pkt_ovf.
REQ-021 sum_valid SHALL hold with stable sum_count and sum_overflow until sum_valid && sum_ready.
REQ-022 A new summary SHALL load in the same cycle that the old one is popped.
REQ-023 A written ID SHALL be visible on m_id / m_valid one cycle after acceptance, so a summary never precedes its IDs.
REQ-024 The FIFO SHALL be first-word fall-through with a registered output and SHALL preserve order.
REQ-025 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-026 A full FIFO SHALL deassert match_release even if a pop occurs in the same cycle (no pass-through).
REQ-027 Occupancy SHALL range 0..DEPTH; the read and write pointers SHALL wrap modulo DEPTH.
REQ-028 m_valid SHALL be 0 when the FIFO is empty; m_id is don't-care while m_valid is 0.
REQ-029 A packet with zero stored IDs SHALL still produce a summary with sum_count = 0.

Reset
REQ-030 While rst_n = 0 at a clock edge, the block SHALL clear the FIFO pointers and occupancy, pkt_cnt, pkt_ovf, sum_valid, sum_count, sum_overflow and all stat counters.
REQ-031 During reset, match_release, m_valid and sum_valid SHALL be 0.
REQ-032 A reset mid-packet SHALL discard the partial packet; the first beat after reset SHALL start a new packet.

Configuration
REQ-033 With macro PIGASUS_MATCH_COLLECTOR_STATS_EN defined, the stat counters SHALL be active as 32-bit wrapping counters:
- stat_pkt: +1 per accepted last beat.
- stat_match: +1 per stored ID.
- stat_drop: +1 per discarded non-null ID.
REQ-034 Without PIGASUS_MATCH_COLLECTOR_STATS_EN, stat_pkt, stat_match and stat_drop SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-035 Single packet, IDs 5, 9, 12 (last on 12), m_ready = 1 -> m_id outputs 5, 9, 12 in order; sum_count = 3, sum_overflow = 0, one cycle after the last beat.
REQ-036 MAX_MATCHES = 8, one packet of 10 non-null IDs -> first 8 popped; sum_count = 8, sum_overflow = 1; stat_drop = 2 (STATS_EN defined).
REQ-037 Single beat ID 0 with last -> nothing popped; sum_count = 0, sum_overflow = 0; stat_pkt = 1, stat_match = 0.
REQ-038 DEPTH = 16, m_ready = 0, 20 IDs offered -> match_release drops after 16 accepts; raising m_ready resumes intake; all 20 IDs delivered in order.
REQ-039 sum_ready = 0 with two packets back-to-back -> the second packet's last beat stalls (match_release = 0) until sum_ready pulses; both summaries are delivered in order.
REQ-040 rst_n asserted after 2 IDs of a packet -> m_valid = 0 and sum_valid = 0; the next packet ID 7 (last) yields sum_count = 1.
